spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Byte-level register-access controller sitting directly downstream of the SPI slave byte engine. It consumes each received MOSI byte (data plus one-cycle completion pulse) and decodes a command/address/data protocol into an internal bank of 8-bit registers. It returns the next MISO byte to the slave's transmit-data input in time for the slave to load it at the start of the following byte. Register contents are exported as a flat bus for the rest of the design.

## Interface
- ADDR_W, 4: register address width; bank holds 2**ADDR_W 8-bit registers; legal range 1..7
- IDLE_BYTE, 8'hA5: byte presented on tx_data while a command byte is being received

- clk  in  1  system clock; one clock for the whole block
- rst  in  1  reset; synchronous and active-low
- spi_cs  in  1  chip select, active-low, already synchronous to clk (same signal the slave sees)
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte
- rx_data  in  8  received MOSI byte, valid when rx_valid=1
- tx_data  out  8  next MISO byte, wired to the slave's transmit-data input
- regs  out  8*2**ADDR_W  register bank; register n at bits [8n+7:8n]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  ADDR_W  address of the register written, valid with wr_strobe
- frame_done  out  1  one-cycle pulse when spi_cs rises after at least one byte in the frame

## Operation
- Frame = spi_cs low period. First byte = command: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = start address; bits[6:ADDR_W] ignored.
- FSM states: CMD, WR_DATA, RD_DATA. Reset state CMD.
- CMD: on rx_valid with spi_cs=0, latch address. Write -> WR_DATA, tx_data <= 8'h00. Read -> RD_DATA, tx_data <= regs[addr], addr <= addr+1.
- WR_DATA: each rx_valid writes regs[addr] <= rx_data, pulses wr_strobe/wr_addr=addr, tx_data <= rx_data (echo), addr <= addr+1.
- RD_DATA: each rx_valid: received byte discarded; tx_data <= regs[addr], addr <= addr+1.
- Address increments modulo 2**ADDR_W (wrap last -> 0).
- spi_cs=1 in any cycle: state <= CMD, tx_data <= IDLE_BYTE. If a frame byte was received since cs fell, frame_done pulses on the first cs=1 cycle.
- rx_valid with spi_cs=1: ignored entirely (no write, no state change).
- Simultaneous last rx_valid and spi_cs rise: not possible by the slave's protocol; if it occurs, rx_valid is ignored, as for any rx_valid with spi_cs=1.
- Read data is sampled at the preload edge; a write to the same register later in another frame is not reflected retroactively.
- Reset values: regs all 0, tx_data = IDLE_BYTE, wr_strobe 0, wr_addr 0, frame_done 0, internal addr 0, state CMD. Reset mid-frame aborts the frame; the block restarts in CMD regardless of spi_cs, and the next byte received is treated as a command.

## Timing
- All outputs registered; all updates on the clk edge that samples rx_valid=1.
- tx_data valid the cycle after the rx_valid cycle; the slave loads it no earlier than two cycles after its completion pulse, so the next byte always carries the new value.
- wr_strobe and the regs update occur in the same cycle, one cycle after rx_valid.
- Back-to-back rx_valid on consecutive cycles must be handled (one byte per pulse, no drops).
- frame_done is one cycle wide, one cycle after the first spi_cs=1 sample.

## Test plan
- Reset: hold rst=0 for 3 cycles -> regs all 0, tx_data=8'hA5, no strobes.
- Write burst: cs low, bytes 8'h83, 8'h11, 8'h22 -> regs[3]=8'h11, regs[4]=8'h22; wr_strobe twice with wr_addr 3 then 4; tx_data sequence 8'h00, 8'h11, 8'h22; cs high -> frame_done pulse, tx_data=8'hA5.
- Read burst: preset regs[3]=8'h11, regs[4]=8'h22; cs low, bytes 8'h03, 8'hFF, 8'hFF -> tx_data 8'h11 after command, 8'h22 after byte 2; no wr_strobe.
- Wrap: ADDR_W=4, write cmd 8'h8F, data 8'hAA, 8'hBB -> regs[15]=8'hAA, regs[0]=8'hBB.
- Abort/ignore: rx_valid with cs high -> no change; cs rise mid-write then new frame with 8'h02 -> treated as read command.
- Reset mid-frame: rst=0 during WR_DATA, then one further byte 8'h05 with cs still low -> regs unchanged, byte 8'h05 decoded as read of address 5.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Register-access controller behind an SPI slave byte engine: decodes command/address/data
// bytes into a bank of 8-bit registers and preloads the next MISO byte.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       spi_cs_i,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_data_i,
    output logic [7:0]                 tx_data_o,
    output logic [8*(2**ADDR_W)-1:0]   regs_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       frame_done_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        StCmd,
        StWrData,
        StRdData
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        regs_q [NumRegs];
    logic [7:0]        tx_data_q;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              frame_done_q;
    logic              seen_q;
    logic [ADDR_W-1:0] cmd_addr;

    assign cmd_addr = rx_data_i[ADDR_W-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StCmd;
            addr_q       <= '0;
            tx_data_q    <= IDLE_BYTE;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            seen_q       <= 1'b0;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_strobe_q  <= 1'b0;
            frame_done_q <= 1'b0;
            // Deselect dominates: any rx_valid seen while cs is high is dropped.
            if (spi_cs_i) begin
                state_q      <= StCmd;
                tx_data_q    <= IDLE_BYTE;
                frame_done_q <= seen_q;
                seen_q       <= 1'b0;
            end else if (rx_valid_i) begin
                seen_q <= 1'b1;
                case (state_q)
                    StCmd: begin
                        if (rx_data_i[7]) begin
                            state_q   <= StWrData;
                            addr_q    <= cmd_addr;
                            tx_data_q <= 8'h00;
                        end else begin
                            state_q   <= StRdData;
                            addr_q    <= cmd_addr + ADDR_W'(1);
                            tx_data_q <= regs_q[cmd_addr];
                        end
                    end
                    StWrData: begin
                        regs_q[addr_q] <= rx_data_i;
                        wr_strobe_q    <= 1'b1;
                        wr_addr_q      <= addr_q;
                        tx_data_q      <= rx_data_i;
                        addr_q         <= addr_q + ADDR_W'(1);
                    end
                    StRdData: begin
                        tx_data_q <= regs_q[addr_q];
                        addr_q    <= addr_q + ADDR_W'(1);
                    end
                    default: state_q <= StCmd;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : gen_regs_flat
        assign regs_o[8*g +: 8] = regs_q[g];
    end

    assign tx_data_o    = tx_data_q;
    assign wr_strobe_o  = wr_strobe_q;
    assign wr_addr_o    = wr_addr_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a byte-level reference model pushes expected responses
// into a scoreboard queue that is popped once the DUT has registered each byte.
module tb_spi_reg_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         spi_cs_i;
    logic         rx_valid_i;
    logic [7:0]   rx_data_i;
    logic [7:0]   tx_data_o;
    logic [127:0] regs_o;
    logic         wr_strobe_o;
    logic [3:0]   wr_addr_o;
    logic         frame_done_o;

    spi_reg_ctrl #(
        .ADDR_W   (4),
        .IDLE_BYTE(8'hA5)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .spi_cs_i    (spi_cs_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .tx_data_o   (tx_data_o),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] tx;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fails  = 0;

    logic [7:0] m_regs [16];
    int         m_state;
    logic [3:0] m_addr;
    logic       m_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_state = 0;
        m_addr  = 4'h0;
        m_seen  = 1'b0;
    endtask

    // Reference behaviour for one byte received with cs low.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        e = '0;
        case (m_state)
            0: begin
                if (b[7]) begin
                    m_state = 1;
                    m_addr  = b[3:0];
                    e.tx    = 8'h00;
                end else begin
                    m_state = 2;
                    e.tx    = m_regs[b[3:0]];
                    m_addr  = b[3:0] + 4'd1;
                end
            end
            1: begin
                m_regs[m_addr] = b;
                e.wr   = 1'b1;
                e.addr = m_addr;
                e.data = b;
                e.tx   = b;
                m_addr = m_addr + 4'd1;
            end
            default: begin
                e.tx   = m_regs[m_addr];
                m_addr = m_addr + 4'd1;
            end
        endcase
        m_seen = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("tx_data", tx_data_o, e.tx);
            chk("wr_strobe", wr_strobe_o, e.wr);
            if (e.wr) begin
                chk("wr_addr", wr_addr_o, e.addr);
                chk("reg_written", regs_o[8*e.addr +: 8], e.data);
            end
        end
    endtask

    // Called at a negedge; calling again right away keeps rx_valid high (back-to-back).
    task automatic drive(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        model_byte(b);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        check_out();
    endtask

    task automatic cs_fall();
        spi_cs_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic cs_rise();
        spi_cs_i = 1'b1;
        @(negedge clk_i);
        chk("frame_done", frame_done_o, m_seen);
        chk("tx_idle", tx_data_o, 8'hA5);
        m_seen  = 1'b0;
        m_state = 0;
        @(negedge clk_i);
        chk("frame_done_width", frame_done_o, 1'b0);
    endtask

    initial begin
        model_reset();
        rst_ni     = 1'b0;
        spi_cs_i   = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        chk("rst_regs", regs_o, 128'h0);
        chk("rst_tx", tx_data_o, 8'hA5);
        chk("rst_wr_strobe", wr_strobe_o, 1'b0);
        chk("rst_frame_done", frame_done_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Write burst with gaps between bytes.
        cs_fall();
        drive(8'h83);
        @(negedge clk_i);
        drive(8'h11);
        @(negedge clk_i);
        drive(8'h22);
        cs_rise();
        chk("wr_regs3", regs_o[31:24], 8'h11);
        chk("wr_regs4", regs_o[39:32], 8'h22);
        chk("wr_all", regs_o, m_flat());

        // Read burst, back-to-back bytes.
        cs_fall();
        drive(8'h03);
        drive(8'hFF);
        drive(8'hFF);
        cs_rise();
        chk("rd_no_change", regs_o, m_flat());

        // Address wrap, back-to-back.
        cs_fall();
        drive(8'h8F);
        drive(8'hAA);
        drive(8'hBB);
        cs_rise();
        chk("wrap_regs15", regs_o[127:120], 8'hAA);
        chk("wrap_regs0", regs_o[7:0], 8'hBB);

        // rx_valid with cs high must be ignored.
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h81;
        @(negedge clk_i);
        rx_data_i  = 8'h33;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        chk("csh_wr_strobe", wr_strobe_o, 1'b0);
        chk("csh_tx", tx_data_o, 8'hA5);
        chk("csh_frame_done", frame_done_o, 1'b0);
        chk("csh_regs", regs_o, m_flat());
        @(negedge clk_i);
        cs_fall();
        drive(8'h03);
        cs_rise();

        // Frame aborted mid-write; next frame's first byte is a read command.
        cs_fall();
        drive(8'h82);
        drive(8'h5C);
        drive(8'h77);
        cs_rise();
        cs_fall();
        drive(8'h02);
        chk("abort_rd_tx", tx_data_o, 8'h5C);
        drive(8'h02);
        cs_rise();

        // Reset during a write frame; next byte decoded as a read command.
        cs_fall();
        drive(8'h85);
        drive(8'h99);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        chk("midrst_regs", regs_o, 128'h0);
        chk("midrst_tx", tx_data_o, 8'hA5);
        drive(8'h05);
        drive(8'h44);
        chk("midrst_after_regs", regs_o, 128'h0);
        cs_rise();

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
